// File: rtl/gcd_engine_param_if.sv
// Operand/result bus for gcd_engine_param. The Cycles signal exists only when
// CYCLE_COUNT_EN is defined.
interface gcd_engine_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             Enter;
  logic             Mode;
  logic [WIDTH-1:0] Input;
  logic [WIDTH-1:0] Output;
  logic             Halt;
  logic             Busy;
  logic             Error;
`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0] Cycles;

  modport master (
    output Enter, Mode, Input,
    input  Output, Halt, Busy, Error, Cycles
  );

  modport slave (
    input  Enter, Mode, Input,
    output Output, Halt, Busy, Error, Cycles
  );
`else
  modport master (
    output Enter, Mode, Input,
    input  Output, Halt, Busy, Error
  );

  modport slave (
    input  Enter, Mode, Input,
    output Output, Halt, Busy, Error
  );
`endif
endinterface

// File: rtl/gcd_engine_param.sv
// Serial-load iterative GCD / X-mod-Y engine with zero-operand rejection.
// Define CYCLE_COUNT_EN to add the saturating COMPUTE cycle counter (Cycles).
module gcd_engine_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic               Clock,
  input logic               Reset,
  gcd_engine_param_if.slave bus
);

  typedef enum logic [1:0] {StLoadX, StLoadY, StCompute, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    out_d   = out_q;
    mode_d  = mode_q;
    err_d   = err_q;
`ifdef CYCLE_COUNT_EN
    cyc_d   = cyc_q;
`endif
    unique case (state_q)
      // DONE accepts a new X exactly like LOAD_X; Output is kept until a new result.
      StLoadX, StDone: begin
        if (bus.Enter) begin
          x_d     = bus.Input;
          mode_d  = bus.Mode;
          err_d   = 1'b0;
`ifdef CYCLE_COUNT_EN
          cyc_d   = '0;
`endif
          state_d = StLoadY;
        end
      end
      StLoadY: begin
        if (bus.Enter) begin
          y_d = bus.Input;
          // Modulo with X==0 is legal and simply resolves to 0.
          if (bus.Input == '0 || (!mode_q && x_q == '0)) begin
            out_d   = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StCompute;
          end
        end
      end
      StCompute: begin
`ifdef CYCLE_COUNT_EN
        if (cyc_q != {CNT_W{1'b1}}) cyc_d = cyc_q + CNT_W'(1);
`endif
        if (mode_q) begin
          if (x_q < y_q) begin
            out_d   = x_q;
            state_d = StDone;
          end else begin
            x_d = x_q - y_q;
          end
        end else begin
          if (x_q == y_q) begin
            out_d   = x_q;
            state_d = StDone;
          end else if (x_q > y_q) begin
            x_d = x_q - y_q;
          end else begin
            y_d = y_q - x_q;
          end
        end
      end
      default: state_d = StLoadX;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StLoadX;
      x_q     <= '0;
      y_q     <= '0;
      out_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CYCLE_COUNT_EN
      cyc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
`ifdef CYCLE_COUNT_EN
      cyc_q   <= cyc_d;
`endif
    end
  end

  assign bus.Output = out_q;
  assign bus.Halt   = (state_q == StDone);
  assign bus.Busy   = (state_q == StCompute);
  assign bus.Error  = err_q;
`ifdef CYCLE_COUNT_EN
  assign bus.Cycles = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_engine_param.sv
// Scoreboard bench for gcd_engine_param: 8-bit and 16-bit instances, directed vectors.
module tb_gcd_engine_param;

  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_engine_param_if #(.WIDTH(8),  .CNT_W(CW)) g8 ();
  gcd_engine_param_if #(.WIDTH(16), .CNT_W(CW)) g16 ();

  gcd_engine_param #(.WIDTH(8), .CNT_W(CW)) dut8 (
    .Clock (clk),
    .Reset (rst),
    .bus   (g8.slave)
  );

  gcd_engine_param #(.WIDTH(16), .CNT_W(CW)) dut16 (
    .Clock (clk),
    .Reset (rst),
    .bus   (g16.slave)
  );

  typedef struct {
    logic [15:0]   out;
    logic          err;
    int unsigned   busy;
    logic [CW-1:0] cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  int unsigned passes = 0;
  int unsigned total  = 0;
  bit          stim_done = 1'b0;

  // Events seen at the active edge, consumed by the monitor half a cycle later.
  logic rst_edge = 1'b0;
  logic drop8    = 1'b0;
  logic drop16   = 1'b0;
  always @(posedge clk) begin
    rst_edge <= rst;
    drop8    <= g8.Enter && g8.Halt && !rst;
    drop16   <= g16.Enter && g16.Halt && !rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run8(input logic mode, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] eout, input logic eerr, input int unsigned ebusy,
                      input bit push);
    exp_t e;
    e.out  = 16'(eout);
    e.err  = eerr;
    e.busy = ebusy;
    e.cyc  = CW'(ebusy);
    if (push) q8.push_back(e);
    @(negedge clk); g8.Enter = 1'b1; g8.Mode = mode;  g8.Input = x;
    @(negedge clk); g8.Mode = ~mode; g8.Input = y;
    @(negedge clk); g8.Enter = 1'b0; g8.Input = '0;
  endtask

  task automatic run16(input logic mode, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] eout, input logic eerr, input int unsigned ebusy);
    exp_t e;
    e.out  = eout;
    e.err  = eerr;
    e.busy = ebusy;
    e.cyc  = CW'(ebusy);
    q16.push_back(e);
    @(negedge clk); g16.Enter = 1'b1; g16.Mode = mode;  g16.Input = x;
    @(negedge clk); g16.Mode = ~mode; g16.Input = y;
    @(negedge clk); g16.Enter = 1'b0; g16.Input = '0;
  endtask

  task automatic wait8(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (g8.Halt) break;
      @(negedge clk);
    end
  endtask

  task automatic wait16(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (g16.Halt) break;
      @(negedge clk);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  initial begin
    int unsigned busy8  = 0;
    int unsigned busy16 = 0;
    logic hprev8  = 1'b0;
    logic hprev16 = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        chk("rst_out8",   32'(g8.Output), 0);
        chk("rst_halt8",  32'(g8.Halt),   0);
        chk("rst_busy8",  32'(g8.Busy),   0);
        chk("rst_err8",   32'(g8.Error),  0);
        chk("rst_out16",  32'(g16.Output), 0);
        chk("rst_halt16", 32'(g16.Halt),   0);
`ifdef CYCLE_COUNT_EN
        chk("rst_cyc8",   32'(g8.Cycles), 0);
`endif
        busy8 = 0; busy16 = 0; hprev8 = 1'b0; hprev16 = 1'b0;
      end else begin
        if (drop8)  chk("halt_drop8",  32'(g8.Halt),  0);
        if (drop16) chk("halt_drop16", 32'(g16.Halt), 0);
        if (g8.Halt && !hprev8) begin
          if (q8.size() == 0) begin
            total++;
            $display("FAIL unexpected_halt8: got Halt with no pending result, expected none");
          end else begin
            e = q8.pop_front();
            chk("out8",  32'(g8.Output), 32'(e.out));
            chk("err8",  32'(g8.Error),  32'(e.err));
            chk("busy8", busy8,          e.busy);
`ifdef CYCLE_COUNT_EN
            chk("cyc8",  32'(g8.Cycles), 32'(e.cyc));
`endif
          end
          busy8 = 0;
        end
        if (g16.Halt && !hprev16) begin
          if (q16.size() == 0) begin
            total++;
            $display("FAIL unexpected_halt16: got Halt with no pending result, expected none");
          end else begin
            e = q16.pop_front();
            chk("out16",  32'(g16.Output), 32'(e.out));
            chk("err16",  32'(g16.Error),  32'(e.err));
            chk("busy16", busy16,          e.busy);
`ifdef CYCLE_COUNT_EN
            chk("cyc16",  32'(g16.Cycles), 32'(e.cyc));
`endif
          end
          busy16 = 0;
        end
        if (g8.Busy)  busy8++;
        if (g16.Busy) busy16++;
        hprev8  = g8.Halt;
        hprev16 = g16.Halt;
      end
      if (stim_done) begin
        chk("q8_drained",  q8.size(),  0);
        chk("q16_drained", q16.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
      end
    end
  end

  initial begin
    g8.Enter  = 1'b0; g8.Mode  = 1'b0; g8.Input  = '0;
    g16.Enter = 1'b0; g16.Mode = 1'b0; g16.Input = '0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run8(1'b0, 8'd48,  8'd18, 8'd6, 1'b0, 5,  1'b1); wait8(50);
    run8(1'b1, 8'd100, 8'd7,  8'd2, 1'b0, 15, 1'b1); wait8(50);
    run8(1'b0, 8'd0,   8'd5,  8'd0, 1'b1, 0,  1'b1); wait8(50);
    run8(1'b1, 8'd0,   8'd9,  8'd0, 1'b0, 1,  1'b1); wait8(50);
    run8(1'b1, 8'd9,   8'd0,  8'd0, 1'b1, 0,  1'b1); wait8(50);

    // Stray Enter while computing must not disturb the operands.
    run8(1'b0, 8'd48, 8'd18, 8'd6, 1'b0, 5, 1'b1);
    @(negedge clk); g8.Enter = 1'b1; g8.Input = 8'd3;
    @(negedge clk); g8.Enter = 1'b0; g8.Input = '0;
    wait8(50);

    // Abort mid-compute; no result is expected from it.
    run8(1'b0, 8'd200, 8'd3, 8'd0, 1'b0, 0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    run8(1'b0, 8'd12, 8'd8,  8'd4, 1'b0, 3, 1'b1); wait8(50);
    run8(1'b0, 8'd21, 8'd14, 8'd7, 1'b0, 3, 1'b1); wait8(50);

    run16(1'b0, 16'd65535, 16'd255, 16'd255, 1'b0, 257); wait16(400);

    @(negedge clk);
    stim_done = 1'b1;
  end

endmodule

// File: doc/gcd_engine_param.md
Name: gcd_engine_param

Overview:
- Parametrised successor of the 8-bit GCD processor.
- Operands X then Y are loaded serially through a single Input bus using Enter pulses, then one of two iterative subtraction computations runs:
  - Mode=0: GCD of X and Y.
  - Mode=1: X mod Y.
- Result is presented on Output with Halt.
- Adds width generalisation, a mode select, zero-operand error reporting, Busy status and an optional cycle counter.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 16, width of the cycle counter (used only with the optional feature).

Ports:
- Clock  in  1  system clock, all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enter  in  1  load strobe; samples Input (and Mode on the X load) at the rising edge.
- Mode  in  1  0 = GCD, 1 = X mod Y; latched with the X operand.
- Input  in  WIDTH  operand data.
- Output  out  WIDTH  result register.
- Halt  out  1  high while a result is valid (state DONE).
- Busy  out  1  high while state is COMPUTE.
- Error  out  1  high with Halt when the operation was rejected for a zero operand.
- Cycles  out  CNT_W  COMPUTE cycle count; present only with CYCLE_COUNT_EN.

Behaviour:
- Reset is synchronous and active-high. At a Reset edge:
  - state = LOAD_X;
  - X, Y, Output, Halt, Busy, Error and Cycles are all 0.
  - Reset overrides Enter and aborts any operation in progress.
- FSM states: LOAD_X, LOAD_Y, COMPUTE, DONE. Halt = (state==DONE); Busy = (state==COMPUTE).
- LOAD_X, Enter=1:
  - X <= Input, mode_r <= Mode.
  - Error <= 0; Cycles <= 0.
  - Go to LOAD_Y.
- LOAD_Y, Enter=1:
  - Y <= Input.
  - Zero check:
    - GCD with X==0 or Input==0 → Output <= 0, Error <= 1, go to DONE.
    - Modulo with Input==0 → Output <= 0, Error <= 1, go to DONE.
    - Modulo with X==0 is legal: it computes to 0.
  - Otherwise go to COMPUTE.
- COMPUTE performs one step per cycle. Cycles increments each COMPUTE cycle, including the final compare cycle.
  - GCD step:
    - X==Y → Output <= X, go to DONE.
    - X>Y → X <= X-Y.
    - else → Y <= Y-X.
  - Modulo step:
    - X<Y → Output <= X, go to DONE.
    - else → X <= X-Y.
- DONE:
  - Output, Error and Cycles hold.
  - Enter=1 acts exactly as in LOAD_X: loads the new X, Halt drops next cycle, go to LOAD_Y.
- Enter during COMPUTE is ignored; operands are not disturbed.
- Latency: Y sampled at edge k → Halt high after edge k+1+n, where n = number of subtraction steps. A zero-operand rejection raises Halt after edge k.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - Subtractions never underflow because of the compare guard.
  - No wrap-around is possible.
- Output keeps the previous result until the next result or Reset; it is not cleared on a new X load.
- Enter held high for several cycles is treated as one load per cycle: the first edge loads X, the second loads Y.

Optional Feature:
- Macro CYCLE_COUNT_EN.
- Defined:
  - Cycles port exists.
  - Counts COMPUTE cycles and saturates at all-ones (no wrap).
  - Cleared on Reset and on each X load.
  - Zero-operand rejection leaves it at 0.
- Undefined: the Cycles port and counter are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, Mode=0, X=48, Y=18 → after 4 subtractions plus the compare cycle, Output=6, Halt=1, Error=0, Cycles=5; Busy high for exactly 5 cycles.
- WIDTH=8, Mode=1, X=100, Y=7 → Output=2, Halt=1, Cycles=15.
- Mode=0, X=0, Y=5 → Halt=1 one edge after the Y load, Error=1, Output=0, Cycles=0. Mode=1, X=0, Y=9 → Output=0, Error=0.
- WIDTH=16, Mode=0, X=65535, Y=255 → Output=255, Cycles=257.
- Enter pulsed with Input=3 during COMPUTE of GCD(48,18) → ignored, result still 6. Reset asserted mid-COMPUTE → next edge all outputs 0, state LOAD_X; the following GCD(12,8) gives 4.
- Back-to-back: from DONE, Enter X=21 then Y=14 without Reset → Halt drops, then Output=7, Halt=1.
